// File: rtl/trigger_conditioner.sv
// trigger_conditioner
//   Front end for the pipelined top level. Synchronises and debounces a raw push-button and
//   emits one fixed-width trigger_val pulse per accepted press. Each accepted press also latches
//   the current value of a free-running 32-bit LFSR as a seed and bumps a wrapping press counter.
//
// Ports
//   clk          in   1      single clock, rising edge
//   rst          in   1      synchronous, active-high reset (priority over everything)
//   btn_raw      in   1      asynchronous raw button level, 1 = pressed
//   trigger_val  out  1      registered; high exactly HOLD_CYCLES cycles per accepted press
//   seed         out  WIDTH  registered; LFSR value captured at press acceptance
//   busy         out  1      registered; high whenever the FSM is not idle
//   press_count  out  8      registered; accepted presses, wraps 255 -> 0
module trigger_conditioner #(
    parameter int unsigned WIDTH           = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 4,
    parameter logic [31:0] LFSR_INIT       = 32'h0000_0001
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    output logic             trigger_val,
    output logic [WIDTH-1:0] seed,
    output logic             busy,
    output logic [7:0]       press_count
);

    localparam int unsigned MAX_CYCLES =
        (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // An all-zero LFSR would lock up, so a zero init value is promoted to 1.
    localparam logic [31:0] LFSR_RST = (LFSR_INIT == 32'h0) ? 32'h0000_0001 : LFSR_INIT;

    typedef enum logic [1:0] {
        StIdle,
        StDebounce,
        StFire,
        StRelease
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             s1_q;
    logic             s2_q;
    logic [31:0]      lfsr_q;

    // Outputs are registered from the next state: each branch sets trigger_val/busy to match
    // the state it moves into, so they line up with state_q one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            lfsr_q      <= LFSR_RST;
            trigger_val <= 1'b0;
            seed        <= '0;
            busy        <= 1'b0;
            press_count <= 8'd0;
        end else begin
            s1_q   <= btn_raw;
            s2_q   <= s1_q;
            lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};

            unique case (state_q)
                StIdle: begin
                    cnt_q       <= '0;
                    trigger_val <= 1'b0;
                    if (s2_q) begin
                        state_q <= StDebounce;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end

                StDebounce: begin
                    if (!s2_q) begin
                        // Glitch shorter than the qualification window.
                        state_q     <= StIdle;
                        cnt_q       <= '0;
                        trigger_val <= 1'b0;
                        busy        <= 1'b0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q     <= StFire;
                        cnt_q       <= '0;
                        trigger_val <= 1'b1;
                        busy        <= 1'b1;
                        seed        <= WIDTH'(lfsr_q);
                        press_count <= press_count + 8'd1;
                    end else begin
                        cnt_q       <= cnt_q + CNT_ONE;
                        trigger_val <= 1'b0;
                        busy        <= 1'b1;
                    end
                end

                StFire: begin
                    // Button level is ignored while the pulse is being emitted.
                    busy <= 1'b1;
                    if (cnt_q == HOLD_LAST) begin
                        state_q     <= StRelease;
                        cnt_q       <= '0;
                        trigger_val <= 1'b0;
                    end else begin
                        cnt_q       <= cnt_q + CNT_ONE;
                        trigger_val <= 1'b1;
                    end
                end

                StRelease: begin
                    trigger_val <= 1'b0;
                    if (s2_q) begin
                        // Bounce or still held: restart release qualification.
                        cnt_q <= '0;
                        busy  <= 1'b1;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        busy  <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= StIdle;
                    cnt_q       <= '0;
                    trigger_val <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_conditioner.sv
// tb_trigger_conditioner
//   Self-checking bench for trigger_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=3,
//   LFSR_INIT=1. A table of hand-derived vectors covers reset and the first press; hand-written
//   sequences cover glitch rejection, release bounce, mid-pulse reset and counter wrap; a random
//   phase compares every cycle against a run-length based reference model.
module tb_trigger_conditioner;

    localparam int unsigned D = 4;
    localparam int unsigned H = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btn_raw = 1'b0;
    logic        trigger_val;
    logic [31:0] seed;
    logic        busy;
    logic [7:0]  press_count;

    int n_cmp  = 0;
    int n_fail = 0;

    trigger_conditioner #(
        .WIDTH           (32),
        .DEBOUNCE_CYCLES (D),
        .HOLD_CYCLES     (H),
        .LFSR_INIT       (32'h0000_0001)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .trigger_val (trigger_val),
        .seed        (seed),
        .busy        (busy),
        .press_count (press_count)
    );

    always #5 clk = ~clk;

    // Reference model: the synchronised level is the button delayed by two edges; a press is
    // accepted on the (D+1)th consecutive high sample seen while waiting, the pulse then lasts
    // H edges regardless of input, and release needs D consecutive low samples.
    int          m_phase;   // 0 waiting for press, 1 pulsing, 2 waiting for release
    int          m_run;
    int          m_hold;
    bit          m_s1;
    bit          m_s2;
    logic [31:0] m_lfsr;
    logic [31:0] m_seed;
    logic [7:0]  m_cnt;
    int          pulses;
    bit          prev_trig;

    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
    endfunction

    task automatic model_step(input logic r, input logic b);
        if (r) begin
            m_phase = 0; m_run = 0; m_hold = 0; m_s1 = 0; m_s2 = 0;
            m_lfsr = 32'h1; m_seed = 32'h0; m_cnt = 8'd0;
            return;
        end
        case (m_phase)
            0: begin
                if (m_s2) begin
                    m_run++;
                    if (m_run == D + 1) begin
                        m_seed  = m_lfsr;
                        m_cnt   = m_cnt + 8'd1;
                        m_phase = 1;
                        m_hold  = 0;
                        m_run   = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            1: begin
                m_hold++;
                if (m_hold == H) begin
                    m_phase = 2;
                    m_run   = 0;
                end
            end
            default: begin
                if (m_s2) m_run = 0;
                else      m_run++;
                if (m_run == D) begin
                    m_phase = 0;
                    m_run   = 0;
                end
            end
        endcase
        m_lfsr = lfsr_next(m_lfsr);
        m_s2   = m_s1;
        m_s1   = b;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check("trigger_val", {31'b0, trigger_val}, {31'b0, (m_phase == 1)});
        check("busy", {31'b0, busy}, {31'b0, (m_phase != 0) || (m_run > 0)});
        check("seed", seed, m_seed);
        check("press_count", {24'b0, press_count}, {24'b0, m_cnt});
    endtask

    // Drive inputs, clock once, advance the model, sample 1ns after the edge.
    task automatic drive(input logic r, input logic b);
        rst     = r;
        btn_raw = b;
        @(posedge clk);
        model_step(r, b);
        #1;
        if (trigger_val && !prev_trig) pulses++;
        prev_trig = trigger_val;
    endtask

    task automatic cycle(input logic r, input logic b);
        drive(r, b);
        check_model();
    endtask

    typedef struct {
        logic        rst;
        logic        btn;
        logic        trig;
        logic        busy;
        logic [31:0] seed;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int p0;
        int k;
        logic [7:0] c0;

        // Reset held with button pressed, then a clean press and release.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  8'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  8'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  8'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  8'd0};  // e0
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  8'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  8'd0};  // e2: debounce starts
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  8'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  8'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,  8'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h6D, 8'd1};  // e6: fire
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h6D, 8'd1};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h6D, 8'd1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h6D, 8'd1};  // e9: release
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h6D, 8'd1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h6D, 8'd1};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h6D, 8'd1};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h6D, 8'd1};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h6D, 8'd1};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h6D, 8'd1};  // e15: idle
        tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h6D, 8'd1};

        pulses    = 0;
        prev_trig = 1'b0;
        model_step(1'b1, 1'b0);

        // T1/T2: table-driven
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].btn);
            check($sformatf("tbl%0d_trig", i), {31'b0, trigger_val}, {31'b0, tbl[i].trig});
            check($sformatf("tbl%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].busy});
            check($sformatf("tbl%0d_seed", i), seed, tbl[i].seed);
            check($sformatf("tbl%0d_cnt", i), {24'b0, press_count}, {24'b0, tbl[i].cnt});
        end

        // T3: short press is rejected
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        p0 = pulses;
        for (int i = 0; i < 3; i++)  cycle(1'b0, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
        check("t3_pulses", pulses - p0, 0);
        check("t3_busy", {31'b0, busy}, 0);
        check("t3_count", {24'b0, press_count}, 0);

        // T4: long hold then a bounce on release
        p0 = pulses;
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 2; i++)  cycle(1'b0, 1'b0);
        for (int i = 0; i < 2; i++)  cycle(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0);
        check("t4_pulses", pulses - p0, 1);
        check("t4_busy", {31'b0, busy}, 0);

        // T5: reset during the second pulse cycle
        cycle(1'b1, 1'b0);
        k = 0;
        while (!trigger_val && k < 20) begin
            cycle(1'b0, 1'b1);
            k++;
        end
        check("t5_fire_seen", {31'b0, trigger_val}, 1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        check("t5_trig", {31'b0, trigger_val}, 0);
        check("t5_busy", {31'b0, busy}, 0);
        check("t5_seed", seed, 0);
        check("t5_count", {24'b0, press_count}, 0);
        // Restarted LFSR must give the same first seed again.
        k = 0;
        while (!trigger_val && k < 20) begin
            cycle(1'b0, 1'b1);
            k++;
        end
        check("t5_refire", {31'b0, trigger_val}, 1);
        check("t5_reseed", seed, 32'h6D);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0);

        // Random stimulus against the model, including occasional resets
        for (int i = 0; i < 300; i++) begin
            logic b;
            int len;
            b   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) cycle(($urandom_range(0, 199) == 0), b);
        end

        // T6: 256 clean presses wrap the counter
        cycle(1'b1, 1'b0);
        p0 = pulses;
        c0 = press_count;
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1);
            check("t6_seed_nonzero", {31'b0, (seed != 32'h0)}, 1);
            for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);
        end
        check("t6_pulses", pulses - p0, 256);
        check("t6_count_wrap", {24'b0, press_count}, {24'b0, c0});
        check("t6_count_zero", {24'b0, press_count}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
